mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (if_*) and data (d_*) ports share one memory.
// Grants are combinational, reads return one cycle later to the granting port.
// Optional starvation guard for the fetch port: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        r_en,
  output logic        w_en,
  output logic [15:0] addr,
  output logic [15:0] w_data,
  input  logic [15:0] r_data
);

  // The limit must fit the 4-bit starvation counter and be non-zero.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {StIdle, StRd, StWr} arb_state_e;

  arb_state_e  arb_state_q, arb_state_d;
  logic        owner_q, owner_d;  // 1: outstanding read belongs to the data port
  logic [15:0] addr_q, addr_d;
  logic [15:0] w_data_q, w_data_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Fetch is forced through once it has lost STARVE_LIMIT contentions in a row.
  always_comb begin
    force_if = (starve_q == STARVE_LIMIT[3:0]) && if_req && d_req;
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = 4'd0;
    end else if (d_gnt && if_req) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Grant, memory drive and response routing; grants are suppressed while in reset.
  always_comb begin
    d_gnt  = reset && d_req && !force_if;
    if_gnt = reset && if_req && !d_gnt;
    r_en   = if_gnt || (d_gnt && !d_we);
    w_en   = d_gnt && d_we;

    addr = addr_q;
    if (if_gnt) begin
      addr = if_addr;
    end else if (d_gnt) begin
      addr = d_addr;
    end
    w_data = w_en ? d_wdata : w_data_q;

    if_rvalid = (arb_state_q == StRd) && !owner_q;
    d_rvalid  = (arb_state_q == StRd) && owner_q;
    if_rdata  = if_rvalid ? r_data : if_rdata_q;
    d_rdata   = d_rvalid ? r_data : d_rdata_q;

    addr_d     = addr;
    w_data_d   = w_data;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    owner_d    = d_gnt;
    if (r_en) begin
      arb_state_d = StRd;
    end else if (w_en) begin
      arb_state_d = StWr;
    end else begin
      arb_state_d = StIdle;
    end
  end

  // State, owner tag and held output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_state_q <= StIdle;
      owner_q     <= 1'b0;
      addr_q      <= 16'h0000;
      w_data_q    <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      d_rdata_q   <= 16'h0000;
    end else begin
      arb_state_q <= arb_state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      w_data_q    <= w_data_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand sequences and random
// traffic compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, r_en, w_en;
  logic [15:0] if_rdata, d_rdata, addr, w_data, r_data;

  mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .r_en(r_en), .w_en(w_en), .addr(addr), .w_data(w_data), .r_data(r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] a;
    a = 16'(i);
    return (a == 16'h0000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // Memory block: synchronous write, read data the cycle after r_en.
  logic [15:0] mem [65536];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (w_en) mem[addr] <= w_data;
      if (r_en) r_data <= mem[addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: shadow memory, one pending response, held values.
  logic [15:0] m_mem [65536];
  logic        m_pend, m_pend_d;
  logic [15:0] m_pend_data, m_addr, m_wdata, m_ifrd, m_drd;
  int          m_cnt;
  logic        e_ig, e_dg, e_ren, e_wen, e_irv, e_drv;
  logic [15:0] e_addr, e_wdata, e_ifrd, e_drd;

  task automatic model_reset();
    m_pend = 1'b0; m_pend_d = 1'b0; m_pend_data = 16'h0;
    m_addr = 16'h0; m_wdata = 16'h0; m_ifrd = 16'h0; m_drd = 16'h0; m_cnt = 0;
  endtask

  task automatic model_check();
    logic starved;
    starved = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starved = (m_cnt == int'(Limit)) && if_req && d_req;
`endif
    e_dg    = d_req && !starved;
    e_ig    = if_req && !e_dg;
    e_ren   = e_ig || (e_dg && !d_we);
    e_wen   = e_dg && d_we;
    e_addr  = e_ig ? if_addr : (e_dg ? d_addr : m_addr);
    e_wdata = e_wen ? d_wdata : m_wdata;
    e_irv   = m_pend && !m_pend_d;
    e_drv   = m_pend && m_pend_d;
    e_ifrd  = e_irv ? m_pend_data : m_ifrd;
    e_drd   = e_drv ? m_pend_data : m_drd;
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("r_en", r_en, e_ren);
    chk("w_en", w_en, e_wen);
    chk("addr", addr, e_addr);
    chk("w_data", w_data, e_wdata);
    chk("if_rvalid", if_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("if_rdata", if_rdata, e_ifrd);
    chk("d_rdata", d_rdata, e_drd);
  endtask

  task automatic model_update();
    m_addr  = e_addr;
    m_wdata = e_wdata;
    m_ifrd  = e_ifrd;
    m_drd   = e_drd;
    m_pend  = e_ren;
    m_pend_d = e_dg;
    m_pend_data = m_mem[e_addr];
    if (e_wen) m_mem[d_addr] = d_wdata;
    if (e_ig) m_cnt = 0;
    else if (e_dg && if_req) m_cnt++;
  endtask

  task automatic apply(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                       input logic [15:0] da, input logic [15:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #2;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_if_gnt"}, if_gnt, 16'h0);
    chk({tag, "_d_gnt"}, d_gnt, 16'h0);
    chk({tag, "_if_rvalid"}, if_rvalid, 16'h0);
    chk({tag, "_d_rvalid"}, d_rvalid, 16'h0);
    chk({tag, "_r_en"}, r_en, 16'h0);
    chk({tag, "_w_en"}, w_en, 16'h0);
    chk({tag, "_addr"}, addr, 16'h0);
    chk({tag, "_w_data"}, w_data, 16'h0);
    chk({tag, "_if_rdata"}, if_rdata, 16'h0);
    chk({tag, "_d_rdata"}, d_rdata, 16'h0);
  endtask

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dwe;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        cur_ir, cur_dr, cur_dwe;
    logic [15:0] cur_ia, cur_da, cur_dwd;
    logic        want;

    for (int i = 0; i < 65536; i++) m_mem[i] = init_val(i);
    model_reset();

    tbl[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hC000, 16'h0102, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hC000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0102};
    tbl[5] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5B5};
    tbl[7] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA585};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5B5};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA585};

    // Reset held with both ports requesting.
    reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 16'h1111; d_addr = 16'h2222; d_wdata = 16'h3333;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk_reset("rst");
    @(negedge clk);
    reset = 1'b1;

    // Directed table: fetch read, data write/read, alternating pipelined reads.
    foreach (tbl[i]) begin
      apply(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
      chk("tbl_if_gnt", if_gnt, tbl[i].e_ig);
      chk("tbl_d_gnt", d_gnt, tbl[i].e_dg);
      chk("tbl_if_rvalid", if_rvalid, tbl[i].e_irv);
      chk("tbl_d_rvalid", d_rvalid, tbl[i].e_drv);
      if (tbl[i].e_irv) chk("tbl_if_rdata", if_rdata, tbl[i].e_rd);
      if (tbl[i].e_drv) chk("tbl_d_rdata", d_rdata, tbl[i].e_rd);
      advance();
    end

    // Sustained contention: both ports read for ten cycles.
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 16'h0000);
`ifdef MEM_ARB_STARVE_GUARD_EN
      want = (k % (Limit + 1)) == Limit;
`else
      want = 1'b0;
`endif
      chk("starve_if_gnt", if_gnt, want);
      chk("starve_d_gnt", d_gnt, !want);
      advance();
    end
    apply(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    advance();

    // Reset asserted right after a read is granted: the response is dropped.
    apply(1'b1, 16'h0007, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    #2;
    chk_reset("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    // First cycle after release: no stale response, fetch granted at once.
    apply(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0);
    advance();
    apply(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    advance();

    // Random traffic; ungranted requests are held stable until granted.
    cur_ir = 1'b0; cur_dr = 1'b0; cur_dwe = 1'b0;
    cur_ia = 16'h0; cur_da = 16'h0; cur_dwd = 16'h0;
    e_ig = 1'b0; e_dg = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!cur_ir || e_ig) begin
        cur_ir = $urandom_range(0, 3) != 0;
        cur_ia = 16'($urandom_range(0, 31));
      end
      if (!cur_dr || e_dg) begin
        cur_dr  = $urandom_range(0, 1) == 1;
        cur_dwe = $urandom_range(0, 1) == 1;
        cur_da  = ($urandom_range(0, 1) == 1) ? 16'(16'hC000 + $urandom_range(0, 7))
                                               : 16'($urandom_range(0, 31));
        cur_dwd = 16'($urandom);
      end
      apply(cur_ir, cur_ia, cur_dr, cur_dwe, cur_da, cur_dwd);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
